aer_in_rx: RTL and testbench
============================

Name: aer_in_rx

Overview:
Receiver end of the 4-phase AER link driven by the core's AER output transmitter. It synchronises the asynchronous request, captures the 14-bit event address `{timestamp[2:0], neuron[10:0]}`, and completes the REQ/ACK handshake. Captured events are buffered in a FIFO and presented to the NPU input scheduler as a valid/ready event stream. AER_IN_BUSY is the back-pressure flag that the transmitter side samples.

Parameters:
DEPTH, 16, event FIFO depth; power of two, at least 2.
AW, 4, log2(DEPTH).
ADDR_DW, 14, AER address width.
NEUR_DW, 11, neuron index field width (AER_IN_ADDR[10:0]).
TS_DW, 3, timestamp field width (AER_IN_ADDR[13:11]).

Ports:
CLK  in  1  system clock; all logic on rising edge.
RST_N  in  1  asynchronous, active-low reset.
AER_IN_REQ  in  1  asynchronous 4-phase request from transmitter.
AER_IN_ADDR  in  14  event address; stable whenever AER_IN_REQ=1.
AER_IN_ACK  out  1  4-phase acknowledge, registered.
AER_IN_BUSY  out  1  FIFO full flag, registered.
EVT_VALID  out  1  FIFO non-empty; head event is presented.
EVT_READY  in  1  consumer accepts head event when EVT_VALID=1.
EVT_NEUR  out  11  head event neuron index.
EVT_TS  out  3  head event timestamp.
EVT_LEVEL  out  AW+1  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset: AER_IN_ACK=0, AER_IN_BUSY=0, EVT_VALID=0, EVT_NEUR=0, EVT_TS=0, EVT_LEVEL=0.
  - Sync flops cleared, FSM set to IDLE, FIFO pointers set to 0.
  - Reset mid-handshake drops ACK immediately; a partially accepted event is not pushed.
- REQ synchroniser: two flops, req_int then req_syn. FSM logic uses req_syn only.
- AER_IN_ADDR is sampled directly (not synchronised) in the cycle the FSM pushes; the protocol holds it stable while REQ is high.
- FSM states:
  - IDLE:
    - req_syn=1 and FIFO not full: push AER_IN_ADDR, set ACK<=1, go to ACK_HI.
    - req_syn=1 and FIFO full: stay in IDLE with no ACK (handshake stalls and no event is lost); proceed when a pop frees a slot.
  - ACK_HI: hold ACK=1 until req_syn=0, then ACK<=0 and go to WAIT_LO.
  - WAIT_LO: one settling cycle, then go to IDLE. This guarantees ACK is low for at least one cycle before a new REQ can be accepted.
- Latency:
  - Push happens in cycle t, where req_syn first reads 1 at cycle t, two edges after REQ rises. ACK is visible at t+1.
  - EVT_VALID rises at t+1 if the FIFO was empty.
- FIFO:
  - First-word-fall-through; EVT_NEUR/EVT_TS are registered views of the head entry.
  - Pop occurs when EVT_VALID & EVT_READY.
  - Pointers are AW bits and wrap modulo DEPTH. Occupancy is a separate AW+1-bit counter.
  - Simultaneous push and pop: count is unchanged and both pointers advance. This is legal on a full FIFO only if the pop is registered first; in this design push is gated by !full in the same cycle, so push and pop on full does not push.
  - EVT_READY while empty is ignored.
- AER_IN_BUSY = (count == DEPTH), registered; it updates one cycle after the push or pop that changes fullness.
- REQ dropped before ACK (protocol violation): FSM stays in IDLE and nothing is pushed.

Decomposition:
- Shared package `aer_pkg`:
  - constants ADDR_DW=14, NEUR_DW=11, TS_DW=3;
  - field-slice localparams (TS_MSB=13, TS_LSB=11, NEUR_MSB=10);
  - rx FSM state encoding IDLE=2'd0, ACK_HI=2'd1, WAIT_LO=2'd2.
- One sub-module, `aer_in_fifo`: parameterised FWFT FIFO with push/pop/full/empty/count.
- The handshake FSM and synchroniser stay in the top module.

Test Plan:
1. Single event: REQ=1 with ADDR=14'h2C05 (TS=5, NEUR=11'h405) -> ACK rises 3 cycles after REQ; EVT_VALID=1 with EVT_TS=5, EVT_NEUR=0x405; after REQ=0, ACK falls within 3 cycles; EVT_LEVEL=1.
2. Burst of 16 events with EVT_READY=0 -> all 16 acknowledged, AER_IN_BUSY=1 after the 16th. A 17th REQ gets no ACK while held for 50 cycles; one EVT_READY pulse then leads to its ACK within 4 cycles and the data order is preserved.
3. Continuous EVT_READY=1 with back-to-back handshakes of addresses 0..39 -> 40 events are output in order, EVT_LEVEL never exceeds 1, BUSY stays 0, and pointer wrap is exercised.
4. Reset asserted while ACK=1 in ACK_HI -> ACK, EVT_VALID, BUSY and EVT_LEVEL are 0 asynchronously; after release, a fresh REQ is handled normally.
5. Pop and push in the same cycle with level=3 -> level stays 3 and the head advances to the next entry.
6. REQ glitch of 1 cycle (shorter than the synchroniser) -> no push and no ACK, or at most one complete handshake; the FSM never hangs and returns to IDLE once REQ is low.

Source files
------------

// File: rtl/aer_pkg.sv
// Shared definitions for the AER input receiver: field widths, address
// slicing positions, handshake FSM encoding and field-extraction helpers.
package aer_pkg;

  localparam int ADDR_DW  = 14;
  localparam int NEUR_DW  = 11;
  localparam int TS_DW    = 3;

  localparam int TS_MSB   = 13;
  localparam int TS_LSB   = 11;
  localparam int NEUR_MSB = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACK_HI  = 2'd1,
    WAIT_LO = 2'd2
  } rx_state_e;

  // Timestamp field of an AER address word.
  function automatic logic [TS_DW-1:0] addr_ts(input logic [ADDR_DW-1:0] addr);
    return addr[TS_MSB:TS_LSB];
  endfunction

  // Neuron index field of an AER address word.
  function automatic logic [NEUR_DW-1:0] addr_neur(input logic [ADDR_DW-1:0] addr);
    return addr[NEUR_MSB:0];
  endfunction

endpackage

// File: rtl/aer_in_rx_if.sv
// AER input link bundle: 4-phase request/acknowledge side toward the
// transmitter plus the valid/ready event stream toward the scheduler.
interface aer_in_rx_if
  import aer_pkg::*;
#(
  parameter int AW = 4
) ();

  logic               AER_IN_REQ;
  logic [ADDR_DW-1:0] AER_IN_ADDR;
  logic               AER_IN_ACK;
  logic               AER_IN_BUSY;
  logic               EVT_VALID;
  logic               EVT_READY;
  logic [NEUR_DW-1:0] EVT_NEUR;
  logic [TS_DW-1:0]   EVT_TS;
  logic [AW:0]        EVT_LEVEL;

  // Receiver side (the aer_in_rx block).
  modport slave (
    input  AER_IN_REQ,
    input  AER_IN_ADDR,
    input  EVT_READY,
    output AER_IN_ACK,
    output AER_IN_BUSY,
    output EVT_VALID,
    output EVT_NEUR,
    output EVT_TS,
    output EVT_LEVEL
  );

  // Transmitter / consumer side.
  modport master (
    output AER_IN_REQ,
    output AER_IN_ADDR,
    output EVT_READY,
    input  AER_IN_ACK,
    input  AER_IN_BUSY,
    input  EVT_VALID,
    input  EVT_NEUR,
    input  EVT_TS,
    input  EVT_LEVEL
  );

endinterface

// File: rtl/aer_in_fifo.sv
// First-word-fall-through event FIFO. The head word, valid/empty/full flags
// and occupancy are all registered, computed from the next-cycle state so
// they change on the same edge as the push or pop that causes them.
module aer_in_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 14
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic          valid,
  output logic [AW:0]   count,
  output logic [DW-1:0] dout
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          full_r;
  logic          empty_r;
  logic          valid_r;
  logic [DW-1:0] dout_r;

  logic          push_ok_s;
  logic          pop_ok_s;
  logic [AW:0]   count_nxt_s;
  logic [AW-1:0] rd_nxt_s;
  logic [DW-1:0] head_nxt_s;

  // A push into a full FIFO and a pop from an empty one are both dropped.
  assign push_ok_s = push & ~full_r;
  assign pop_ok_s  = pop  & ~empty_r;

  // Next occupancy, next read pointer and the word that will sit at the head.
  always_comb begin
    count_nxt_s = count_r;
    rd_nxt_s    = rd_ptr_r;
    head_nxt_s  = dout_r;

    if (push_ok_s && !pop_ok_s) begin
      count_nxt_s = count_r + (AW+1)'(1'b1);
    end else if (pop_ok_s && !push_ok_s) begin
      count_nxt_s = count_r - (AW+1)'(1'b1);
    end else begin
      count_nxt_s = count_r;
    end

    if (pop_ok_s) begin
      rd_nxt_s = rd_ptr_r + AW'(1'b1);
    end else begin
      rd_nxt_s = rd_ptr_r;
    end

    // The incoming word becomes the head only when it lands exactly where the
    // read pointer will point, i.e. the FIFO is about to hold just this word.
    if (push_ok_s && (wr_ptr_r == rd_nxt_s)) begin
      head_nxt_s = din;
    end else if (count_nxt_s != '0) begin
      head_nxt_s = mem_r[rd_nxt_s];
    end else begin
      head_nxt_s = dout_r;
    end
  end

  // Pointers, occupancy, flags and the registered head view.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
      valid_r  <= 1'b0;
      dout_r   <= '0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      rd_ptr_r <= rd_nxt_s;
      count_r  <= count_nxt_s;
      full_r   <= (count_nxt_s == DEPTH_C);
      empty_r  <= (count_nxt_s == '0);
      valid_r  <= (count_nxt_s != '0);
      dout_r   <= head_nxt_s;
    end
  end

  // Storage array; only accepted pushes write it.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign full  = full_r;
  assign empty = empty_r;
  assign valid = valid_r;
  assign count = count_r;
  assign dout  = dout_r;

endmodule

// File: rtl/aer_in_rx.sv
// AER input receiver: synchronises the asynchronous 4-phase request,
// captures the event address into a FWFT FIFO and completes the REQ/ACK
// handshake. A full FIFO stalls the handshake (no ACK) so no event is lost.
module aer_in_rx
  import aer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RST_N,
  aer_in_rx_if.slave  aer
);

  logic               req_int_r;
  logic               req_syn_r;
  rx_state_e          state_r;
  rx_state_e          state_nxt_s;
  logic               ack_r;
  logic               ack_nxt_s;
  logic               push_s;
  logic               pop_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               fifo_valid_s;
  logic [AW:0]        fifo_count_s;
  logic [ADDR_DW-1:0] fifo_dout_s;

  // Two-flop synchroniser for the asynchronous request.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      req_int_r <= 1'b0;
      req_syn_r <= 1'b0;
    end else begin
      req_int_r <= aer.AER_IN_REQ;
      req_syn_r <= req_int_r;
    end
  end

  // Handshake state and registered acknowledge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= IDLE;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ack_r   <= ack_nxt_s;
    end
  end

  // Handshake sequencing: accept in IDLE when there is room, hold ACK until
  // the request drops, then keep ACK low for one settling cycle.
  always_comb begin
    state_nxt_s = state_r;
    ack_nxt_s   = ack_r;
    push_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_syn_r && !fifo_full_s) begin
          push_s      = 1'b1;
          ack_nxt_s   = 1'b1;
          state_nxt_s = ACK_HI;
        end else begin
          ack_nxt_s   = 1'b0;
          state_nxt_s = IDLE;
        end
      end
      ACK_HI: begin
        if (!req_syn_r) begin
          ack_nxt_s   = 1'b0;
          state_nxt_s = WAIT_LO;
        end else begin
          ack_nxt_s   = 1'b1;
          state_nxt_s = ACK_HI;
        end
      end
      WAIT_LO: begin
        ack_nxt_s   = 1'b0;
        state_nxt_s = IDLE;
      end
      default: begin
        ack_nxt_s   = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Consumer accepts the head only while an event is actually presented.
  assign pop_s = ~fifo_empty_s & aer.EVT_READY;

  aer_in_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (ADDR_DW)
  ) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (push_s),
    .din   (aer.AER_IN_ADDR),
    .pop   (pop_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .valid (fifo_valid_s),
    .count (fifo_count_s),
    .dout  (fifo_dout_s)
  );

  assign aer.AER_IN_ACK  = ack_r;
  assign aer.AER_IN_BUSY = fifo_full_s;
  assign aer.EVT_VALID   = fifo_valid_s;
  assign aer.EVT_NEUR    = addr_neur(fifo_dout_s);
  assign aer.EVT_TS      = addr_ts(fifo_dout_s);
  assign aer.EVT_LEVEL   = fifo_count_s;

endmodule

// File: tb/tb_aer_in_rx.sv
// Self-checking bench for aer_in_rx: table-driven field vectors, directed
// multi-cycle corner cases and a randomized run, all observed by a queue
// model of the event stream sampled on the falling clock edge.
module tb_aer_in_rx;
  import aer_pkg::*;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  aer_in_rx_if #(.AW(AW)) bus ();

  aer_in_rx #(.DEPTH(DEPTH), .AW(AW)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .aer   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queue of accepted events -------------
  logic [13:0] model_q [$];
  logic [13:0] mon_head;
  bit          mon_en     = 1'b0;
  bit          pop_pend   = 1'b0;
  bit          ack_prev   = 1'b0;
  bit          busy_seen  = 1'b0;
  bit          rand_ready = 1'b0;
  int          max_level  = 0;
  int          pops_seen  = 0;

  // Every acknowledged request adds its address to the stream; every cycle
  // with a presented event and READY high removes the oldest one.
  always @(negedge clk) begin
    if (!mon_en) begin
      model_q.delete();
      pop_pend = 1'b0;
      ack_prev = bus.AER_IN_ACK;
    end else begin
      if (pop_pend) begin
        void'(model_q.pop_front());
        pops_seen++;
      end
      if (bus.AER_IN_ACK && !ack_prev) model_q.push_back(bus.AER_IN_ADDR);
      ack_prev = bus.AER_IN_ACK;
      check("level", 32'(bus.EVT_LEVEL), 32'(model_q.size()));
      check("valid", 32'(bus.EVT_VALID), 32'(model_q.size() != 0));
      check("busy", 32'(bus.AER_IN_BUSY), 32'(model_q.size() == DEPTH));
      if (model_q.size() != 0) begin
        mon_head = model_q[0];
        check("head_ts", 32'(bus.EVT_TS), 32'(mon_head[13:11]));
        check("head_neur", 32'(bus.EVT_NEUR), 32'(mon_head[10:0]));
      end
      if (int'(bus.EVT_LEVEL) > max_level) max_level = int'(bus.EVT_LEVEL);
      if (bus.AER_IN_BUSY) busy_seen = 1'b1;
      pop_pend = (model_q.size() != 0) && bus.EVT_READY;
    end
  end

  // ---------------- stimulus helpers --------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
    if (rand_ready) bus.EVT_READY = 1'($urandom_range(0, 1));
  endtask

  task automatic reset_dut();
    mon_en = 1'b0;
    rand_ready = 1'b0;
    bus.AER_IN_REQ = 1'b0;
    bus.EVT_READY = 1'b0;
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;
    step();
  endtask

  // One full 4-phase handshake; returns cycles to ACK rise and to ACK fall.
  task automatic send(input logic [13:0] a, output int lat_r, output int lat_f);
    bus.AER_IN_ADDR = a;
    bus.AER_IN_REQ = 1'b1;
    lat_r = 0;
    while (!bus.AER_IN_ACK && lat_r < 40) begin
      step();
      lat_r++;
    end
    check("ack_rise", 32'(bus.AER_IN_ACK), 32'd1);
    bus.AER_IN_REQ = 1'b0;
    lat_f = 0;
    while (bus.AER_IN_ACK && lat_f < 40) begin
      step();
      lat_f++;
    end
    check("ack_fall", 32'(bus.AER_IN_ACK), 32'd0);
  endtask

  task automatic drain();
    int n;
    rand_ready = 1'b0;
    bus.EVT_READY = 1'b1;
    n = 0;
    while (bus.EVT_VALID && n < 100) begin
      step();
      n++;
    end
    repeat (2) step();
    bus.EVT_READY = 1'b0;
    check("drained", 32'(bus.EVT_LEVEL), 32'd0);
  endtask

  typedef struct {
    logic [13:0] addr;
    logic [2:0]  ts;
    logic [10:0] neur;
  } vec_t;

  vec_t        vt [6];
  logic [13:0] ev [4];
  int          lr, lf, n, acks, p0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{14'h2C05, 3'd5, 11'h405};
    vt[1] = '{14'h0000, 3'd0, 11'h000};
    vt[2] = '{14'h3FFF, 3'd7, 11'h7FF};
    vt[3] = '{14'h0800, 3'd1, 11'h000};
    vt[4] = '{14'h07FF, 3'd0, 11'h7FF};
    vt[5] = '{14'h1A3C, 3'd3, 11'h23C};

    bus.AER_IN_REQ = 1'b0;
    bus.AER_IN_ADDR = 14'h0000;
    bus.EVT_READY = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", 32'(bus.AER_IN_ACK), 32'd0);
    check("rst_busy", 32'(bus.AER_IN_BUSY), 32'd0);
    check("rst_valid", 32'(bus.EVT_VALID), 32'd0);
    check("rst_neur", 32'(bus.EVT_NEUR), 32'd0);
    check("rst_ts", 32'(bus.EVT_TS), 32'd0);
    check("rst_level", 32'(bus.EVT_LEVEL), 32'd0);
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;
    step();

    // Field-split vectors; the first also measures handshake latency.
    for (int i = 0; i < 6; i++) begin
      send(vt[i].addr, lr, lf);
      if (i == 0) begin
        check("ack_latency", 32'(lr), 32'd3);
        check("ack_fall_le3", 32'(lf <= 3), 32'd1);
      end
      check("vec_ts", 32'(bus.EVT_TS), 32'(vt[i].ts));
      check("vec_neur", 32'(bus.EVT_NEUR), 32'(vt[i].neur));
      check("vec_level", 32'(bus.EVT_LEVEL), 32'd1);
      bus.EVT_READY = 1'b1;
      step();
      bus.EVT_READY = 1'b0;
      check("vec_pop_level", 32'(bus.EVT_LEVEL), 32'd0);
    end

    // Fill to full, stall a 17th request, release it with a single pop.
    reset_dut();
    for (int i = 0; i < DEPTH; i++) send(14'($urandom), lr, lf);
    check("full_busy", 32'(bus.AER_IN_BUSY), 32'd1);
    check("full_level", 32'(bus.EVT_LEVEL), 32'(DEPTH));
    bus.AER_IN_ADDR = 14'($urandom);
    bus.AER_IN_REQ = 1'b1;
    acks = 0;
    repeat (50) begin
      step();
      if (bus.AER_IN_ACK) acks++;
    end
    check("stall_no_ack", 32'(acks), 32'd0);
    bus.EVT_READY = 1'b1;
    step();
    bus.EVT_READY = 1'b0;
    n = 0;
    while (!bus.AER_IN_ACK && n < 10) begin
      step();
      n++;
    end
    check("ack_after_pop_le4", 32'(n <= 4), 32'd1);
    bus.AER_IN_REQ = 1'b0;
    n = 0;
    while (bus.AER_IN_ACK && n < 10) begin
      step();
      n++;
    end
    check("stall_ack_fall", 32'(bus.AER_IN_ACK), 32'd0);
    drain();

    // Back-to-back handshakes with a consumer that is always ready.
    reset_dut();
    bus.EVT_READY = 1'b1;
    p0 = pops_seen;
    max_level = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 40; i++) send(14'(i), lr, lf);
    repeat (3) step();
    check("stream_count", 32'(pops_seen - p0), 32'd40);
    check("stream_level_le1", 32'(max_level <= 1), 32'd1);
    check("stream_busy_never", 32'(busy_seen), 32'd0);
    bus.EVT_READY = 1'b0;

    // Asynchronous reset while ACK is high.
    reset_dut();
    bus.AER_IN_ADDR = 14'h1555;
    bus.AER_IN_REQ = 1'b1;
    n = 0;
    while (!bus.AER_IN_ACK && n < 10) begin
      step();
      n++;
    end
    check("mid_ack_high", 32'(bus.AER_IN_ACK), 32'd1);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_ack", 32'(bus.AER_IN_ACK), 32'd0);
    check("arst_valid", 32'(bus.EVT_VALID), 32'd0);
    check("arst_busy", 32'(bus.AER_IN_BUSY), 32'd0);
    check("arst_level", 32'(bus.EVT_LEVEL), 32'd0);
    bus.AER_IN_REQ = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    mon_en = 1'b1;
    step();
    send(14'h2A93, lr, lf);
    check("post_rst_level", 32'(bus.EVT_LEVEL), 32'd1);
    check("post_rst_neur", 32'(bus.EVT_NEUR), 32'h293);
    check("post_rst_ts", 32'(bus.EVT_TS), 32'd5);
    drain();

    // Push and pop on the same edge with three events queued.
    reset_dut();
    for (int i = 0; i < 4; i++) ev[i] = 14'($urandom);
    for (int i = 0; i < 3; i++) send(ev[i], lr, lf);
    bus.AER_IN_ADDR = ev[3];
    bus.AER_IN_REQ = 1'b1;
    step();
    step();
    bus.EVT_READY = 1'b1;
    step();
    bus.EVT_READY = 1'b0;
    check("pp_ack", 32'(bus.AER_IN_ACK), 32'd1);
    check("pp_level", 32'(bus.EVT_LEVEL), 32'd3);
    check("pp_head", 32'({bus.EVT_TS, bus.EVT_NEUR}), 32'(ev[1]));
    bus.AER_IN_REQ = 1'b0;
    repeat (4) step();
    drain();

    // One-cycle request glitch: at most one complete handshake, then idle.
    reset_dut();
    bus.AER_IN_ADDR = 14'h0ABC;
    bus.AER_IN_REQ = 1'b1;
    step();
    bus.AER_IN_REQ = 1'b0;
    repeat (8) step();
    check("glitch_ack_low", 32'(bus.AER_IN_ACK), 32'd0);
    check("glitch_level_le1", 32'(bus.EVT_LEVEL <= 1), 32'd1);
    send(14'h3123, lr, lf);
    drain();

    // Randomized handshakes against a randomly stalling consumer.
    reset_dut();
    p0 = pops_seen;
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(14'($urandom), lr, lf);
      repeat ($urandom_range(0, 3)) step();
    end
    drain();
    check("rand_count", 32'(pops_seen - p0), 32'd150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
